// File: rtl/sync_fifo_bram_if.sv
// rtl/sync_fifo_bram_if.sv - handshake and status bundle for sync_fifo_bram
//
// Purpose: groups the write, read, status and error signals of the FIFO so the
// producer/consumer side (master) and the FIFO itself (slave) share one port.
//
// Signals:
//   data_in      WIDTH      write data (master -> fifo)
//   wr_en        1          write request
//   rd_en        1          read request (standard) / pop (FWFT)
//   clr_err      1          clears the sticky error flags
//   data_out     WIDTH      read data (fifo -> master)
//   data_valid   1          data_out holds a popped (standard) / head (FWFT) word
//   full         1          no free RAM entries
//   almost_full  1          count >= AFULL_THR
//   empty        1          no readable entries
//   almost_empty 1          count <= AEMPTY_THR
//   count        PTR_LEN+1  words held, 0..DEPTH
//   overflow     1          sticky: write seen while full
//   underflow    1          sticky: read seen while empty
interface sync_fifo_bram_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   localparam int PTR_LEN = $clog2(DEPTH);

   logic [WIDTH-1:0]   data_in;
   logic               wr_en;
   logic               rd_en;
   logic               clr_err;
   logic [WIDTH-1:0]   data_out;
   logic               data_valid;
   logic               full;
   logic               almost_full;
   logic               empty;
   logic               almost_empty;
   logic [PTR_LEN:0]   count;
   logic               overflow;
   logic               underflow;

   modport master (
      output data_in, wr_en, rd_en, clr_err,
      input  data_out, data_valid, full, almost_full, empty, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  data_in, wr_en, rd_en, clr_err,
      output data_out, data_valid, full, almost_full, empty, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_bram.sv
// rtl/sync_fifo_bram.sv - single-clock FIFO around an inferable simple-dual-port RAM
//
// Purpose: buffers frame bytes between MAC stages in one clock domain. Pointer
// based full/empty, fill count, programmable almost flags, sticky overflow and
// underflow, and a selectable standard or first-word-fall-through read mode.
//
// Ports:
//   i_clk   in   single clock, all logic on the rising edge
//   i_rst   in   synchronous reset, active-high
//   bus     slave modport of sync_fifo_bram_if (data, handshake, status, errors)
//
// Read path is two registers deep in both modes: a RAM read register (r_mid_*)
// followed by the output register. Standard mode: read accepted at edge N shows
// on data_out after edge N+1. FWFT mode: the two registers form a prefetch
// pipeline fed by a separate prefetch pointer, so rd_ptr only advances when the
// head word leaves the output register; this keeps count (wr_ptr - rd_ptr)
// inclusive of prefetched words and bounded by DEPTH, and keeps full correct.
module sync_fifo_bram #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 16,
   parameter int PTR_LEN    = $clog2(DEPTH),
   parameter int FWFT       = 0,
   parameter int AFULL_THR  = DEPTH - 2,
   parameter int AEMPTY_THR = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   sync_fifo_bram_if.slave   bus
);

   localparam int               PTR_W    = PTR_LEN + 1;
   localparam bit               L_FWFT   = (FWFT != 0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] L_AFULL  = PTR_W'(AFULL_THR);
   localparam logic [PTR_W-1:0] L_AEMPTY = PTR_W'(AEMPTY_THR);

   logic [WIDTH-1:0]   r_mem [DEPTH];

   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_pf_ptr;
   logic [WIDTH-1:0]   r_mid_data;
   logic               r_mid_vld;
   logic [WIDTH-1:0]   r_data_out;
   logic               r_data_valid;
   logic               r_overflow;
   logic               r_underflow;

   logic               w_full;
   logic               w_empty;
   logic [PTR_W-1:0]   w_count;
   logic               w_wr_acc;
   logic               w_rd_acc;
   logic               w_pf_avail;
   logic               w_out_load;
   logic               w_ram_rd;
   logic [PTR_LEN-1:0] w_rd_addr;

   // Status is derived from registered pointers/registers only.
   assign w_full  = (r_wr_ptr[PTR_LEN] != r_rd_ptr[PTR_LEN]) &&
                    (r_wr_ptr[PTR_LEN-1:0] == r_rd_ptr[PTR_LEN-1:0]);
   assign w_count = r_wr_ptr - r_rd_ptr;
   assign w_empty = L_FWFT ? !r_data_valid : (r_wr_ptr == r_rd_ptr);

   assign w_wr_acc = bus.wr_en && !w_full;
   assign w_rd_acc = bus.rd_en && !w_empty;

   // FWFT prefetch: the output register reloads when it is free or being
   // popped; the RAM is read whenever the mid register will be free after
   // this edge, which keeps one word per cycle flowing on back-to-back pops.
   assign w_pf_avail = (r_pf_ptr != r_wr_ptr);
   assign w_out_load = r_mid_vld && (!r_data_valid || w_rd_acc);
   assign w_ram_rd   = L_FWFT ? (w_pf_avail && (!r_mid_vld || w_out_load))
                              : w_rd_acc;
   assign w_rd_addr  = L_FWFT ? r_pf_ptr[PTR_LEN-1:0] : r_rd_ptr[PTR_LEN-1:0];

   // RAM array and its read register carry no reset so they map onto block RAM.
   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr[PTR_LEN-1:0]] <= bus.data_in;
      end
      if (w_ram_rd) begin
         r_mid_data <= r_mem[w_rd_addr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_pf_ptr     <= '0;
         r_mid_vld    <= 1'b0;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_ram_rd) begin
            r_pf_ptr <= r_pf_ptr + PTR_ONE;
         end

         if (L_FWFT) begin
            if (w_ram_rd) begin
               r_mid_vld <= 1'b1;
            end else if (w_out_load) begin
               r_mid_vld <= 1'b0;
            end
            if (w_out_load) begin
               r_data_out   <= r_mid_data;
               r_data_valid <= 1'b1;
            end else if (w_rd_acc) begin
               r_data_valid <= 1'b0;
            end
         end else begin
            // Standard mode: r_mid_vld marks a read issued last edge; data_out
            // keeps its last value when nothing new arrives.
            r_mid_vld <= w_rd_acc;
            if (r_mid_vld) begin
               r_data_out <= r_mid_data;
            end
            r_data_valid <= r_mid_vld;
         end

         // A set event in the same cycle as clr_err takes priority.
         if (bus.wr_en && w_full) begin
            r_overflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
         end
         if (bus.rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end else if (bus.clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign bus.data_out     = r_data_out;
   assign bus.data_valid   = r_data_valid;
   assign bus.full         = w_full;
   assign bus.almost_full  = (w_count >= L_AFULL);
   assign bus.empty        = w_empty;
   assign bus.almost_empty = (w_count <= L_AEMPTY);
   assign bus.count        = w_count;
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_bram.sv
// tb/tb_sync_fifo_bram.sv - scoreboard bench for sync_fifo_bram in standard and FWFT modes
module tb_sync_fifo_bram;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sync_fifo_bram_if #(.WIDTH(8), .DEPTH(16)) s_if ();
   sync_fifo_bram_if #(.WIDTH(8), .DEPTH(16)) f_if ();

   sync_fifo_bram #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (s_if.slave)
   );

   sync_fifo_bram #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (f_if.slave)
   );

   int         n_chk = 0;
   int         n_err = 0;
   int         mcnt  = 0;
   logic [7:0] q  [$];
   logic [7:0] qf [$];
   logic [7:0] exp_s;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one standard-mode cycle and advances the reference model.
   task automatic s_drive(input bit wr, input logic [7:0] d, input bit rd);
      bit acc_w;
      bit acc_r;
      s_if.wr_en   = wr;
      s_if.data_in = d;
      s_if.rd_en   = rd;
      acc_w = wr && (mcnt < 16);
      acc_r = rd && (mcnt > 0);
      if (acc_w) q.push_back(d);
      mcnt = mcnt + int'(acc_w) - int'(acc_r);
      tick();
      s_if.wr_en = 1'b0;
      s_if.rd_en = 1'b0;
   endtask

   // Scoreboard consumer for the standard-mode DUT.
   always @(negedge clk) begin
      if (!rst && s_if.data_valid) begin
         n_chk++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL std_unexpected_word got %02h required no word", s_if.data_out);
         end else begin
            exp_s = q.pop_front();
            if (s_if.data_out !== exp_s) begin
               n_err++;
               $display("FAIL std_data got %02h required %02h", s_if.data_out, exp_s);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_chk++;
      if ({s_if.count, s_if.empty, s_if.almost_empty, s_if.full, s_if.almost_full} !== {5'd0, 4'b1100}) begin
         n_err++;
         $display("FAIL reset_status got %b required %b",
                  {s_if.count, s_if.empty, s_if.almost_empty, s_if.full, s_if.almost_full}, {5'd0, 4'b1100});
      end
      n_chk++;
      if ({s_if.data_out, s_if.data_valid, s_if.overflow, s_if.underflow} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_data got %h required 0",
                  {s_if.data_out, s_if.data_valid, s_if.overflow, s_if.underflow});
      end
      n_chk++;
      if ({f_if.empty, f_if.data_valid, f_if.count} !== {2'b10, 5'd0}) begin
         n_err++;
         $display("FAIL reset_fwft got %b required %b", {f_if.empty, f_if.data_valid, f_if.count}, {2'b10, 5'd0});
      end
      rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) begin
         s_drive(1'b1, 8'(i), 1'b0);
         n_chk++;
         if ({s_if.count, s_if.almost_full, s_if.full, s_if.almost_empty} !==
             {5'(mcnt), mcnt >= 14, mcnt == 16, mcnt <= 2}) begin
            n_err++;
            $display("FAIL fill_status i=%0d got %b required %b", i,
                     {s_if.count, s_if.almost_full, s_if.full, s_if.almost_empty},
                     {5'(mcnt), mcnt >= 14, mcnt == 16, mcnt <= 2});
         end
      end
      for (int k = 0; k < 18; k++) begin
         s_drive(1'b0, 8'h00, k < 16);
         n_chk++;
         if (s_if.data_valid !== (k >= 1 && k <= 16)) begin
            n_err++;
            $display("FAIL drain_latency k=%0d got %b required %b", k, s_if.data_valid, (k >= 1 && k <= 16));
         end
      end
      n_chk++;
      if ({s_if.empty, s_if.count} !== {1'b1, 5'd0} || q.size() != 0) begin
         n_err++;
         $display("FAIL drain_end got empty=%b count=%0d pending=%0d required 1 0 0",
                  s_if.empty, s_if.count, q.size());
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) s_drive(1'b1, 8'h80 + 8'(i), 1'b0);
      s_drive(1'b1, 8'hAA, 1'b0);
      n_chk++;
      if ({s_if.overflow, s_if.count, s_if.full} !== {1'b1, 5'd16, 1'b1}) begin
         n_err++;
         $display("FAIL overflow_set got %b required %b", {s_if.overflow, s_if.count, s_if.full}, {1'b1, 5'd16, 1'b1});
      end
      s_if.clr_err = 1'b1;
      s_drive(1'b1, 8'hAB, 1'b0);
      n_chk++;
      if (s_if.overflow !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_set_beats_clr got %b required 1", s_if.overflow);
      end
      s_drive(1'b0, 8'h00, 1'b0);
      s_if.clr_err = 1'b0;
      n_chk++;
      if (s_if.overflow !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_clr got %b required 0", s_if.overflow);
      end
      for (int k = 0; k < 19; k++) s_drive(1'b0, 8'h00, k < 16);
      n_chk++;
      if (q.size() != 0 || s_if.empty !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_drain got pending=%0d empty=%b required 0 1", q.size(), s_if.empty);
      end
   endtask

   task automatic test_wrap();
      int  nxt = 0;
      bit  w;
      bit  r;
      for (int c = 0; c < 400 && !(nxt == 40 && mcnt == 0); c++) begin
         w = (nxt < 40) && (mcnt < 12) && (mcnt < 3 || $urandom_range(0, 1) == 1);
         r = (mcnt > 0) && (nxt == 40 || (mcnt > 3 && $urandom_range(0, 1) == 1));
         s_drive(w, 8'(nxt), r);
         if (w) nxt++;
         n_chk++;
         if ({s_if.count, s_if.empty, s_if.full, s_if.almost_full, s_if.almost_empty} !==
             {5'(mcnt), mcnt == 0, 1'b0, mcnt >= 14, mcnt <= 2}) begin
            n_err++;
            $display("FAIL wrap_status c=%0d got %b required %b", c,
                     {s_if.count, s_if.empty, s_if.full, s_if.almost_full, s_if.almost_empty},
                     {5'(mcnt), mcnt == 0, 1'b0, mcnt >= 14, mcnt <= 2});
         end
      end
      for (int k = 0; k < 3; k++) s_drive(1'b0, 8'h00, 1'b0);
      n_chk++;
      if (nxt != 40 || q.size() != 0) begin
         n_err++;
         $display("FAIL wrap_complete got written=%0d pending=%0d required 40 0", nxt, q.size());
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) s_drive(1'b1, 8'h40 + 8'(i), 1'b0);
      for (int i = 0; i < 5; i++) begin
         s_drive(1'b1, 8'h60 + 8'(i), 1'b1);
         n_chk++;
         if (s_if.count !== 5'd8) begin
            n_err++;
            $display("FAIL simul_count8 i=%0d got %0d required 8", i, s_if.count);
         end
      end
      for (int k = 0; k < 11; k++) s_drive(1'b0, 8'h00, k < 8);
      for (int i = 0; i < 5; i++) begin
         s_drive(1'b1, 8'h70 + 8'(i), 1'b1);
         n_chk++;
         if ({s_if.underflow, s_if.count} !== {1'b1, 5'd1}) begin
            n_err++;
            $display("FAIL simul_empty i=%0d got %b required %b", i, {s_if.underflow, s_if.count}, {1'b1, 5'd1});
         end
      end
      for (int k = 0; k < 4; k++) s_drive(1'b0, 8'h00, k == 0);
      s_if.clr_err = 1'b1;
      s_drive(1'b0, 8'h00, 1'b0);
      s_if.clr_err = 1'b0;
      n_chk++;
      if (s_if.underflow !== 1'b0 || q.size() != 0) begin
         n_err++;
         $display("FAIL simul_end got underflow=%b pending=%0d required 0 0", s_if.underflow, q.size());
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 9; i++) s_drive(1'b1, 8'h30 + 8'(i), 1'b0);
      n_chk++;
      if (s_if.count !== 5'd9) begin
         n_err++;
         $display("FAIL midop_count got %0d required 9", s_if.count);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      mcnt = 0;
      n_chk++;
      if ({s_if.count, s_if.empty, s_if.data_valid, s_if.full, s_if.almost_full,
           s_if.overflow, s_if.underflow, s_if.data_out} !== {5'd0, 6'b100000, 8'h00}) begin
         n_err++;
         $display("FAIL midop_reset got %b required %b",
                  {s_if.count, s_if.empty, s_if.data_valid, s_if.full, s_if.almost_full,
                   s_if.overflow, s_if.underflow, s_if.data_out}, {5'd0, 6'b100000, 8'h00});
      end
      s_drive(1'b1, 8'h5A, 1'b0);
      s_drive(1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 3; k++) s_drive(1'b0, 8'h00, 1'b0);
      n_chk++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL midop_readback got pending=%0d required 0", q.size());
      end
   endtask

   task automatic test_fwft();
      f_if.wr_en   = 1'b1;
      f_if.data_in = 8'h11;
      tick();
      f_if.wr_en = 1'b0;
      n_chk++;
      if (f_if.data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fwft_n got %b required 0", f_if.data_valid);
      end
      tick();
      n_chk++;
      if (f_if.data_valid !== 1'b0) begin
         n_err++;
         $display("FAIL fwft_n1 got %b required 0", f_if.data_valid);
      end
      tick();
      n_chk++;
      if ({f_if.data_valid, f_if.data_out, f_if.empty, f_if.count} !== {1'b1, 8'h11, 1'b0, 5'd1}) begin
         n_err++;
         $display("FAIL fwft_n2 got %h required %h",
                  {f_if.data_valid, f_if.data_out, f_if.empty, f_if.count}, {1'b1, 8'h11, 1'b0, 5'd1});
      end
      f_if.rd_en = 1'b1;
      tick();
      f_if.rd_en = 1'b0;
      n_chk++;
      if ({f_if.data_valid, f_if.empty, f_if.count, f_if.underflow} !== {2'b01, 5'd0, 1'b0}) begin
         n_err++;
         $display("FAIL fwft_pop1 got %b required %b", {f_if.data_valid, f_if.empty, f_if.count, f_if.underflow},
                  {2'b01, 5'd0, 1'b0});
      end
      f_if.rd_en = 1'b1;
      tick();
      f_if.rd_en = 1'b0;
      n_chk++;
      if (f_if.underflow !== 1'b1) begin
         n_err++;
         $display("FAIL fwft_underflow got %b required 1", f_if.underflow);
      end
      for (int i = 0; i < 8; i++) begin
         f_if.wr_en   = 1'b1;
         f_if.data_in = 8'h20 + 8'(i);
         qf.push_back(8'h20 + 8'(i));
         tick();
      end
      f_if.wr_en = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      n_chk++;
      if ({f_if.count, f_if.data_valid} !== {5'd8, 1'b1}) begin
         n_err++;
         $display("FAIL fwft_prefill got %b required %b", {f_if.count, f_if.data_valid}, {5'd8, 1'b1});
      end
      f_if.rd_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_s = qf.pop_front();
         n_chk++;
         if ({f_if.data_valid, f_if.data_out} !== {1'b1, exp_s}) begin
            n_err++;
            $display("FAIL fwft_stream k=%0d got %h required %h", k, {f_if.data_valid, f_if.data_out}, {1'b1, exp_s});
         end
         tick();
      end
      f_if.rd_en = 1'b0;
      n_chk++;
      if ({f_if.empty, f_if.data_valid, f_if.count} !== {2'b10, 5'd0}) begin
         n_err++;
         $display("FAIL fwft_end got %b required %b", {f_if.empty, f_if.data_valid, f_if.count}, {2'b10, 5'd0});
      end
   endtask

   initial begin
      rst          = 1'b1;
      s_if.wr_en   = 1'b0;
      s_if.rd_en   = 1'b0;
      s_if.clr_err = 1'b0;
      s_if.data_in = 8'h00;
      f_if.wr_en   = 1'b0;
      f_if.rd_en   = 1'b0;
      f_if.clr_err = 1'b0;
      f_if.data_in = 8'h00;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_wrap();
      test_simultaneous();
      test_reset_midop();
      test_fwft();
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
